// File: rtl/prog_sequencer_if.sv
// Bus bundle between the program sequencer, its instruction ROM and the
// processor control FSM.
//   mem_addr : ROM address driven by the sequencer
//   mem_q    : ROM read data, valid one cycle after mem_addr is applied
//   din      : instruction word presented to the processor
//   run      : one-cycle pulse issuing din
//   done     : instruction-complete pulse from the control FSM
// master = sequencer side, slave = ROM / processor side.
interface prog_sequencer_if #(
  parameter int unsigned ADDR_W = 5
) ();
  logic [ADDR_W-1:0] mem_addr;
  logic [15:0]       mem_q;
  logic [15:0]       din;
  logic              run;
  logic              done;

  modport master (
    output mem_addr,
    output din,
    output run,
    input  mem_q,
    input  done
  );

  modport slave (
    input  mem_addr,
    input  din,
    input  run,
    output mem_q,
    output done
  );
endinterface

// File: rtl/prog_sequencer.sv
// Program-level sequencer: fetches instruction words from a synchronous ROM,
// issues each one exactly once with a single run pulse, waits for done, then
// advances the program counter. Stops on HALT_WORD, after LAST_ADDR, or on a
// halt request taken at an instruction boundary.
//
// Ports:
//   clk         : system clock (also clocks the ROM)
//   reset       : synchronous, active-high reset
//   start       : begin a program from address 0 when IDLE/HALTED/ERROR
//   halt_req    : request to stop at the next instruction boundary
//   bus         : master side of prog_sequencer_if (mem_addr, mem_q, din, run, done)
//   pc          : current program counter
//   busy        : high in FETCH, WAIT, ISSUE, EXEC
//   halted      : high in HALTED
//   err         : watchdog error flag
//   instr_count : completed instructions, saturating
//
// Optional feature: define SEQ_WATCHDOG_EN to build a done-timeout watchdog
// that moves EXEC to ERROR after WDOG_CYCLES cycles without done. Without it
// EXEC waits indefinitely and err is tied low.
module prog_sequencer #(
  parameter int unsigned ADDR_W      = 5,
  parameter int unsigned LAST_ADDR   = 31,
  parameter logic [15:0] HALT_WORD   = 16'hFFFF,
  parameter int unsigned WDOG_CYCLES = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 halt_req,
  prog_sequencer_if.master     bus,
  output logic [ADDR_W-1:0]    pc,
  output logic                 busy,
  output logic                 halted,
  output logic                 err,
  output logic [15:0]          instr_count
);

  localparam logic [ADDR_W-1:0] LastPc = ADDR_W'(LAST_ADDR);

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StWait,
    StIssue,
    StExec,
    StHalted,
    StError
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [15:0]       din_q, din_d;
  logic [15:0]       cnt_q, cnt_d;
  logic              halt_q, halt_d;
  logic              wdog_expired;

`ifdef SEQ_WATCHDOG_EN
  localparam int unsigned WdogW = $clog2(WDOG_CYCLES + 1);
  localparam logic [WdogW-1:0] WdogLast = WdogW'(WDOG_CYCLES - 1);

  logic [WdogW-1:0] wdog_q, wdog_d;

  // Counts EXEC cycles; zero on the first EXEC cycle because it is cleared
  // everywhere else. The limit is reached on the cycle that would make it
  // WDOG_CYCLES; done in that cycle takes priority in the FSM.
  always_comb begin
    wdog_d = '0;
    if (state_q == StExec) begin
      wdog_d = wdog_q + WdogW'(1);
    end
  end

  assign wdog_expired = (state_q == StExec) && (wdog_q == WdogLast);

  always_ff @(posedge clk) begin
    if (reset) begin
      wdog_q <= '0;
    end else begin
      wdog_q <= wdog_d;
    end
  end

  assign err = (state_q == StError);
`else
  logic unused_wdog;
  assign unused_wdog  = ^WDOG_CYCLES;
  assign wdog_expired = 1'b0;
  assign err          = 1'b0;
`endif

  assign busy = (state_q == StFetch) || (state_q == StWait) ||
                (state_q == StIssue) || (state_q == StExec);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    din_d   = din_q;
    cnt_d   = cnt_q;
    halt_d  = halt_q;

    // Sticky halt request, only observed at instruction boundaries.
    if (busy && halt_req) begin
      halt_d = 1'b1;
    end

    unique case (state_q)
      StIdle, StHalted, StError: begin
        if (start) begin
          pc_d    = '0;
          cnt_d   = '0;
          halt_d  = 1'b0;
          state_d = StFetch;
        end
      end
      StFetch: begin
        state_d = StWait;
      end
      StWait: begin
        if (bus.mem_q == HALT_WORD) begin
          state_d = StHalted;
        end else if (halt_q) begin
          state_d = StHalted;
        end else begin
          din_d   = bus.mem_q;
          state_d = StIssue;
        end
      end
      StIssue: begin
        state_d = StExec;
      end
      StExec: begin
        if (bus.done) begin
          cnt_d = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
          if ((pc_q == LastPc) || halt_q || halt_req) begin
            state_d = StHalted;
          end else begin
            pc_d    = pc_q + ADDR_W'(1);
            state_d = StFetch;
          end
        end else if (wdog_expired) begin
          state_d = StError;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      pc_q    <= '0;
      din_q   <= '0;
      cnt_q   <= '0;
      halt_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      din_q   <= din_d;
      cnt_q   <= cnt_d;
      halt_q  <= halt_d;
    end
  end

  assign bus.mem_addr = pc_q;
  assign bus.din      = din_q;
  assign bus.run      = (state_q == StIssue);
  assign pc           = pc_q;
  assign halted       = (state_q == StHalted);
  assign instr_count  = cnt_q;

endmodule

// File: tb/tb_prog_sequencer.sv
// Directed bench for prog_sequencer: synchronous ROM model, a control-FSM
// stand-in that returns done two cycles after run, and hand-computed checks.
module tb_prog_sequencer;

  logic        clk;
  logic        reset;
  logic        start;
  logic        halt_req;
  logic [4:0]  pc;
  logic        busy;
  logic        halted;
  logic        err;
  logic [15:0] instr_count;

  prog_sequencer_if #(.ADDR_W(5)) bus ();

  prog_sequencer #(
    .ADDR_W     (5),
    .LAST_ADDR  (31),
    .HALT_WORD  (16'hFFFF),
    .WDOG_CYCLES(64)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .halt_req   (halt_req),
    .bus        (bus.master),
    .pc         (pc),
    .busy       (busy),
    .halted     (halted),
    .err        (err),
    .instr_count(instr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous ROM
  logic [15:0] rom [32];
  always @(posedge clk) bus.mem_q <= rom[bus.mem_addr];

  // Control FSM stand-in: done two cycles after run
  logic auto_en;
  logic man_done;
  logic run_d1;
  logic done_auto;
  always @(posedge clk) begin
    run_d1    <= bus.run;
    done_auto <= run_d1;
  end
  assign bus.done = (auto_en & done_auto) | man_done;

  // Monitors (cumulative; tests compare deltas)
  int unsigned run_cnt  = 0;
  int unsigned pc2_cnt  = 0;
  int unsigned wrap_cnt = 0;
  logic [4:0]  prev_pc  = '0;
  logic [15:0] din_log[$];
  always @(negedge clk) begin
    if (bus.run) begin
      run_cnt <= run_cnt + 1;
      din_log.push_back(bus.din);
    end
    if (busy && pc == 5'd2) pc2_cnt <= pc2_cnt + 1;
    if (prev_pc == 5'd31 && pc == 5'd0) wrap_cnt <= wrap_cnt + 1;
    prev_pc <= pc;
  end

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_halted(input string tag, input int budget);
    int n;
    n = 0;
    while (!halted && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_halt_reached"}, {31'd0, halted}, 32'd1);
  endtask

  task automatic wait_run_at(input string tag, input logic [4:0] at_pc, input int budget);
    int  n;
    logic hit;
    n   = 0;
    hit = 1'b0;
    while (!hit && n < budget) begin
      @(negedge clk);
      n++;
      hit = bus.run && (pc == at_pc);
    end
    check({tag, "_run_reached"}, {31'd0, hit}, 32'd1);
  endtask

  int unsigned runs0, pc20, wrap0, idx0;
  logic [15:0] exp_din [3];

  initial begin
    reset    = 1'b0;
    start    = 1'b0;
    halt_req = 1'b0;
    auto_en  = 1'b1;
    man_done = 1'b0;
    for (int i = 0; i < 32; i++) rom[i] = 16'h0000;

    // Reset state
    do_reset();
    check("rst_run", {31'd0, bus.run}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_halted", {31'd0, halted}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_pc", {27'd0, pc}, 32'd0);
    check("rst_cnt", {16'd0, instr_count}, 32'd0);
    check("rst_din", {16'd0, bus.din}, 32'd0);

    // Tests 1 & 2: short program ending in HALT_WORD, with start latency
    rom[0] = 16'h1000; rom[1] = 16'h2001; rom[2] = 16'h0045; rom[3] = 16'hFFFF;
    exp_din[0] = 16'h1000; exp_din[1] = 16'h2001; exp_din[2] = 16'h0045;
    runs0 = run_cnt;
    idx0  = din_log.size();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);            // edge k has sampled start
    start = 1'b0;
    check("lat_k_addr", {27'd0, bus.mem_addr}, 32'd0);
    check("lat_k_busy", {31'd0, busy}, 32'd1);
    check("lat_k_run", {31'd0, bus.run}, 32'd0);
    @(negedge clk);            // after k+1
    check("lat_k1_run", {31'd0, bus.run}, 32'd0);
    @(negedge clk);            // after k+2
    check("lat_k2_run", {31'd0, bus.run}, 32'd1);
    check("lat_k2_din", {16'd0, bus.din}, 32'h1000);
    @(negedge clk);
    check("lat_k3_run", {31'd0, bus.run}, 32'd0);
    wait_halted("t1", 200);
    @(negedge clk);
    check("t1_runs", run_cnt - runs0, 32'd3);
    for (int i = 0; i < 3; i++) begin
      if (din_log.size() > idx0 + i) check($sformatf("t1_din%0d", i), {16'd0, din_log[idx0 + i]},
                                           {16'd0, exp_din[i]});
      else check($sformatf("t1_din%0d_missing", i), 32'd0, 32'd1);
    end
    check("t1_pc", {27'd0, pc}, 32'd3);
    check("t1_cnt", {16'd0, instr_count}, 32'd3);
    check("t1_busy", {31'd0, busy}, 32'd0);
    check("t1_din_hold", {16'd0, bus.din}, 32'h0045);

    // done outside EXEC is ignored
    @(negedge clk);
    man_done = 1'b1;
    @(negedge clk);
    man_done = 1'b0;
    @(negedge clk);
    check("idle_done_cnt", {16'd0, instr_count}, 32'd3);
    check("idle_done_halted", {31'd0, halted}, 32'd1);

    // Test 3: halt request during EXEC of address 1
    for (int i = 0; i < 32; i++) rom[i] = 16'h0011 + 16'(i);
    runs0 = run_cnt;
    pc20  = pc2_cnt;
    pulse_start();
    wait_run_at("t3", 5'd1, 100);
    @(negedge clk);            // first EXEC cycle of address 1
    halt_req = 1'b1;
    @(negedge clk);
    halt_req = 1'b0;
    wait_halted("t3", 50);
    @(negedge clk);
    check("t3_pc", {27'd0, pc}, 32'd1);
    check("t3_cnt", {16'd0, instr_count}, 32'd2);
    check("t3_runs", run_cnt - runs0, 32'd2);
    check("t3_no_fetch2", pc2_cnt - pc20, 32'd0);

    // Test 4: run to LAST_ADDR with no halt word
    runs0 = run_cnt;
    wrap0 = wrap_cnt;
    pulse_start();
    wait_halted("t4", 600);
    repeat (3) @(negedge clk);
    check("t4_runs", run_cnt - runs0, 32'd32);
    check("t4_pc", {27'd0, pc}, 32'd31);
    check("t4_cnt", {16'd0, instr_count}, 32'd32);
    check("t4_no_wrap", wrap_cnt - wrap0, 32'd0);

    // Test 5: start while busy ignored, reset in EXEC of address 5
    pulse_start();
    wait_run_at("t5a", 5'd2, 100);
    start = 1'b1;              // sampled in ISSUE
    @(negedge clk);
    start = 1'b0;
    wait_run_at("t5b", 5'd5, 100);
    check("t5_cnt_at5", {16'd0, instr_count}, 32'd5);
    @(negedge clk);            // EXEC, done still pending
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("t5_run", {31'd0, bus.run}, 32'd0);
    check("t5_busy", {31'd0, busy}, 32'd0);
    check("t5_pc", {27'd0, pc}, 32'd0);
    check("t5_cnt", {16'd0, instr_count}, 32'd0);
    repeat (3) @(negedge clk);  // stale done from the responder lands here
    check("t5_post_cnt", {16'd0, instr_count}, 32'd0);
    check("t5_post_busy", {31'd0, busy}, 32'd0);

    // Test 6: done withheld
    auto_en = 1'b0;
    pulse_start();
    wait_run_at("t6", 5'd0, 20);
`ifdef SEQ_WATCHDOG_EN
    repeat (64) @(negedge clk);
    check("t6_busy_at_limit", {31'd0, busy}, 32'd1);
    check("t6_err_at_limit", {31'd0, err}, 32'd0);
    @(negedge clk);
    check("t6_err", {31'd0, err}, 32'd1);
    check("t6_err_busy", {31'd0, busy}, 32'd0);
    check("t6_err_pc", {27'd0, pc}, 32'd0);
    check("t6_err_cnt", {16'd0, instr_count}, 32'd0);
    auto_en = 1'b1;
    pulse_start();
    check("t6_restart_err", {31'd0, err}, 32'd0);
    check("t6_restart_busy", {31'd0, busy}, 32'd1);
    check("t6_restart_addr", {27'd0, bus.mem_addr}, 32'd0);
`else
    repeat (100) @(negedge clk);
    check("t6_err", {31'd0, err}, 32'd0);
    check("t6_busy", {31'd0, busy}, 32'd1);
    check("t6_pc", {27'd0, pc}, 32'd0);
    check("t6_cnt", {16'd0, instr_count}, 32'd0);
    auto_en = 1'b1;
`endif
    do_reset();
    check("end_busy", {31'd0, busy}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Global time guard
  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/prog_sequencer.md
Name: prog_sequencer

Overview:
- Program-level sequencer for the simple processor.
- Fetches 16-bit instruction words from the synchronous instruction ROM and presents each word on DIN.
- Pulses run once per instruction, waits for the control FSM's done, then advances the program counter.
- Replaces the free-running address counter, so instructions issue exactly once and in order. Stops on a halt word, the last address, or a halt request.

Parameters:
- ADDR_W, 5, instruction memory address width.
- LAST_ADDR, 31, final program address; sequencing stops after this instruction completes.
- HALT_WORD, 16'hFFFF, fetched word that terminates the program without issuing it.
- WDOG_CYCLES, 64, done-timeout limit in cycles (used only with the optional feature).

Ports:
- clk, input, 1, system clock; also clocks the instruction ROM.
- reset, input, 1, synchronous, active-high reset.
- start, input, 1, level or pulse; begins a program from address 0 when in IDLE, HALTED or ERROR.
- halt_req, input, 1, request to stop at the next instruction boundary.
- mem_addr, output, ADDR_W, ROM address; equals pc.
- mem_q, input, 16, ROM read data, valid one cycle after the address is applied.
- din, output, 16, registered instruction word to the processor DIN.
- run, output, 1, one-cycle pulse issuing din to the control FSM.
- done, input, 1, instruction-complete pulse from the control FSM.
- pc, output, ADDR_W, current program counter.
- busy, output, 1, high in FETCH, WAIT, ISSUE and EXEC.
- halted, output, 1, high in HALTED.
- err, output, 1, watchdog error flag.
- instr_count, output, 16, number of completed instructions.

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high.
- Reset (sampled on the clk edge): state=IDLE; pc, din, instr_count=0; run, busy, halted, err=0; halt latch cleared. Reset overrides every other input. Asserting reset mid-instruction drops run and busy in the following cycle.
- States: IDLE, FETCH, WAIT, ISSUE, EXEC, HALTED, ERROR.
- IDLE/HALTED/ERROR with start=1: pc=0, instr_count=0, halted=0, err=0, halt latch cleared, go to FETCH.
- FETCH: mem_addr=pc is applied for one cycle; go to WAIT.
- WAIT: capture mem_q.
  - If mem_q==HALT_WORD, go to HALTED; pc holds and run is not asserted.
  - Else if the halt latch is set, go to HALTED without issuing.
  - Otherwise din<=mem_q and go to ISSUE.
- ISSUE: run=1 for exactly this one cycle; go to EXEC. din is stable from ISSUE until EXEC exits.
- EXEC: wait for done=1.
  - On done: instr_count increments, saturating at 16'hFFFF.
  - If pc==LAST_ADDR or the halt latch is set (including halt_req in this same cycle), go to HALTED.
  - Otherwise pc<=pc+1 and go to FETCH.
- Latency: start sampled at edge k gives run high in the cycle after edge k+2. Steady-state issue overhead is 3 cycles per instruction plus execute time.
- done outside EXEC is ignored.
- start while busy is ignored.
- halt_req is sampled every busy cycle into a sticky latch. It takes effect only at an instruction boundary (WAIT or the done cycle) and never aborts an issued instruction.
- pc never wraps; reaching LAST_ADDR always ends in HALTED.
- Outputs: busy=1 only in FETCH/WAIT/ISSUE/EXEC; halted=1 only in HALTED; run=1 only in ISSUE.

Optional Feature:
- SEQ_WATCHDOG_EN defined:
  - A cycle counter clears on entry to EXEC and increments each EXEC cycle without done.
  - When it reaches WDOG_CYCLES, go to ERROR: err=1, busy=0; pc and instr_count hold.
  - done in the same cycle as the limit wins (normal completion).
  - ERROR exits only via start or reset.
- SEQ_WATCHDOG_EN undefined: no counter is built, err is tied to 0, EXEC waits indefinitely, and ERROR is unreachable.

Test Plan:
1. ROM words 0-3 = 16'h1000, 16'h2001, 16'h0045, 16'hFFFF; done returned 2 cycles after each run; pulse start → run pulses exactly 3 times; din equals 16'h1000, 16'h2001, 16'h0045 in order; HALTED with pc=3, instr_count=3; run never asserted for 16'hFFFF.
2. start at edge k → mem_addr=0 from k, run=1 only in the cycle after k+2, din=ROM[0] in that cycle.
3. halt_req pulsed 1 cycle during EXEC of address 1 → instruction 1 completes; HALTED with pc=1, instr_count=2; no fetch of address 2.
4. ROM filled with no HALT_WORD; LAST_ADDR=31 → 32 run pulses; HALTED with pc=31, instr_count=32; pc never shows 0 after 31.
5. reset asserted in EXEC at address 5 → next cycle run=0, busy=0, pc=0, instr_count=0; extra done pulses and start-while-busy are ignored.
6. SEQ_WATCHDOG_EN with WDOG_CYCLES=64, done withheld → err=1 and ERROR after 64 EXEC cycles; a subsequent start clears err and refetches address 0. Without the macro → err stays 0 and busy stays 1.
